// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the Sargantana instruction cache.
package sargantana_icache_pkg;

    localparam int ICACHE_N_WAY_DEF = 4;
    localparam int TAG_DEPTH_DEF    = 64;
    localparam int TAG_WIDHT_DEF    = 20;

    // Tag controller states. The encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOOKUP      = 3'd1,
        MISS_REQ    = 3'd2,
        WAIT_REFILL = 3'd3,
        WRITE_TAG   = 3'd4,
        FLUSH       = 3'd5
    } icache_tagctl_state_t;

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way selection: the lowest-index invalid way wins. When every way is
// valid, the round-robin pointer supplies the victim. The pointer only moves
// when the controller pulses advance_i after a round-robin replacement.
module sargantana_icache_victim_sel #(
    parameter int N_WAY = 4,
    localparam int IDX_W = $clog2(N_WAY)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [N_WAY-1:0] vbit_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] victim_o,
    output logic             from_rr_o
);

    logic [IDX_W-1:0] rr_q, rr_d;

    // Priority encoder over invalid ways; falls back to the round-robin pointer.
    always_comb begin
        victim_o  = rr_q;
        from_rr_o = 1'b1;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (!vbit_i[w]) begin
                victim_o  = IDX_W'(w);
                from_rr_o = 1'b0;
            end
        end
    end

    // Pointer advance; wraps naturally because N_WAY is a power of two.
    always_comb begin
        rr_d = advance_i ? rr_q + IDX_W'(1) : rr_q;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/sargantana_icache_tag_ctrl.sv
// Tag lookup and miss controller for the Sargantana instruction cache.
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; a producer holding valid keeps its payload stable until that cycle,
// and valid is never withdrawn before it. resp_valid_o is a one-cycle pulse
// with no back-pressure.
module sargantana_icache_tag_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int ICACHE_N_WAY   = ICACHE_N_WAY_DEF,
    parameter int TAG_DEPTH      = TAG_DEPTH_DEF,
    parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int TAG_WIDHT      = TAG_WIDHT_DEF
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           flush_i,
    input  logic                           lookup_valid_i,
    output logic                           lookup_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]      lookup_idx_i,
    input  logic [TAG_WIDHT-1:0]           lookup_ptag_i,
    output logic                           resp_valid_o,
    output logic                           resp_hit_o,
    output logic [ICACHE_N_WAY-1:0]        resp_way_o,
    output logic                           mreq_valid_o,
    input  logic                           mreq_ready_i,
    output logic [TAG_ADDR_WIDHT-1:0]      mreq_idx_o,
    output logic [TAG_WIDHT-1:0]           mreq_ptag_o,
    input  logic                           refill_done_i,
    output logic [ICACHE_N_WAY-1:0]        tm_req_o,
    output logic                           tm_we_o,
    output logic                           tm_vbit_o,
    output logic                           tm_flush_o,
    output logic [TAG_WIDHT-1:0]           tm_data_o,
    output logic [TAG_ADDR_WIDHT-1:0]      tm_addr_o,
    input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tm_tag_way_i,
    input  logic [ICACHE_N_WAY-1:0]        tm_vbit_i,
    output logic [2:0]                     state_o
);

    localparam int WIDX_W = $clog2(ICACHE_N_WAY);
    localparam logic [ICACHE_N_WAY-1:0] WAY_ONE = {{(ICACHE_N_WAY-1){1'b0}}, 1'b1};

    icache_tagctl_state_t      state_q, state_d;
    logic [TAG_ADDR_WIDHT-1:0] idx_q, idx_d;
    logic [TAG_WIDHT-1:0]      ptag_q, ptag_d;
    logic [WIDX_W-1:0]         victim_q, victim_d;
    logic                      from_rr_q, from_rr_d;
    logic                      flush_pend_q, flush_pend_d;

    logic [ICACHE_N_WAY-1:0]   hit;
    logic [ICACHE_N_WAY-1:0]   hit_way;
    logic [ICACHE_N_WAY-1:0]   victim_oh;
    logic [WIDX_W-1:0]         sel_victim;
    logic                      sel_from_rr;
    logic                      rr_advance;
    logic                      take;

    sargantana_icache_victim_sel #(
        .N_WAY (ICACHE_N_WAY)
    ) u_victim_sel (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .vbit_i    (tm_vbit_i),
        .advance_i (rr_advance),
        .victim_o  (sel_victim),
        .from_rr_o (sel_from_rr)
    );

    // Per-way tag compare against the latched physical tag; lowest hit wins.
    always_comb begin
        hit = '0;
        for (int w = 0; w < ICACHE_N_WAY; w++) begin
            hit[w] = tm_vbit_i[w] && (tm_tag_way_i[w*TAG_WIDHT +: TAG_WIDHT] == ptag_q);
        end
        hit_way   = hit & (~hit + WAY_ONE);
        victim_oh = WAY_ONE << victim_q;
    end

    // Next-state and output decode. Outputs not owned by the current state stay 0.
    always_comb begin
        lookup_ready_o = 1'b0;
        resp_valid_o   = 1'b0;
        resp_hit_o     = 1'b0;
        resp_way_o     = '0;
        mreq_valid_o   = 1'b0;
        mreq_idx_o     = '0;
        mreq_ptag_o    = '0;
        tm_req_o       = '0;
        tm_we_o        = 1'b0;
        tm_vbit_o      = 1'b0;
        tm_flush_o     = 1'b0;
        tm_data_o      = '0;
        tm_addr_o      = '0;
        state_d        = state_q;
        idx_d          = idx_q;
        ptag_d         = ptag_q;
        victim_d       = victim_q;
        from_rr_d      = from_rr_q;
        flush_pend_d   = flush_pend_q;
        rr_advance     = 1'b0;
        take           = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else begin
                    // Held low while in reset so nothing is accepted then.
                    lookup_ready_o = rstn_i;
                    take           = lookup_valid_i && rstn_i;
                end
            end
            LOOKUP: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (|hit) begin
                    resp_valid_o   = 1'b1;
                    resp_hit_o     = 1'b1;
                    resp_way_o     = hit_way;
                    lookup_ready_o = 1'b1;
                    take           = lookup_valid_i;
                    state_d        = IDLE;
                end else begin
                    victim_d  = sel_victim;
                    from_rr_d = sel_from_rr;
                    state_d   = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mreq_valid_o = 1'b1;
                mreq_idx_o   = idx_q;
                mreq_ptag_o  = ptag_q;
                if (flush_i) flush_pend_d = 1'b1;
                if (mreq_ready_i) state_d = WAIT_REFILL;
            end
            WAIT_REFILL: begin
                if (flush_i) flush_pend_d = 1'b1;
                if (refill_done_i) begin
                    state_d = (flush_pend_q || flush_i) ? FLUSH : WRITE_TAG;
                end
            end
            WRITE_TAG: begin
                tm_req_o     = victim_oh;
                tm_we_o      = 1'b1;
                tm_vbit_o    = 1'b1;
                tm_data_o    = ptag_q;
                tm_addr_o    = idx_q;
                resp_valid_o = 1'b1;
                resp_way_o   = victim_oh;
                rr_advance   = from_rr_q;
                state_d      = flush_i ? FLUSH : IDLE;
            end
            FLUSH: begin
                tm_flush_o   = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accepting a lookup fires a read to every way of the requested set.
        if (take) begin
            tm_req_o  = '1;
            tm_addr_o = lookup_idx_i;
            idx_d     = lookup_idx_i;
            ptag_d    = lookup_ptag_i;
            state_d   = LOOKUP;
        end
    end

    // State and latched request registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ptag_q       <= '0;
            victim_q     <= '0;
            from_rr_q    <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptag_q       <= ptag_d;
            victim_q     <= victim_d;
            from_rr_q    <= from_rr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign state_o = state_q;

    // A tag may live in at most one way of a set.
    assert property (@(posedge clk_i) disable iff (!rstn_i)
        (state_q == LOOKUP) |-> $onehot0(hit));

endmodule

// File: tb/tb_sargantana_icache_tag_ctrl.sv
// Directed bench for the icache tag controller with a behavioural tag memory
// and a response scoreboard.
module tb_sargantana_icache_tag_ctrl;
    import sargantana_icache_pkg::*;

    localparam int NW = 4;
    localparam int TD = 64;
    localparam int AW = 6;
    localparam int TW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush_i = 0, lookup_valid_i = 0, mreq_ready_i = 0, refill_done_i = 0;
    logic [AW-1:0] lookup_idx_i = '0;
    logic [TW-1:0] lookup_ptag_i = '0;
    logic          lookup_ready_o, resp_valid_o, resp_hit_o, mreq_valid_o;
    logic [NW-1:0] resp_way_o, tm_req_o;
    logic [AW-1:0] mreq_idx_o, tm_addr_o;
    logic [TW-1:0] mreq_ptag_o, tm_data_o;
    logic          tm_we_o, tm_vbit_o, tm_flush_o;
    logic [NW*TW-1:0] rd_tag;
    logic [NW-1:0] rd_v;
    logic [2:0]    state_o;

    sargantana_icache_tag_ctrl dut (
        .clk_i(clk), .rstn_i(rst_n), .flush_i(flush_i),
        .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
        .lookup_idx_i(lookup_idx_i), .lookup_ptag_i(lookup_ptag_i),
        .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o),
        .mreq_valid_o(mreq_valid_o), .mreq_ready_i(mreq_ready_i),
        .mreq_idx_o(mreq_idx_o), .mreq_ptag_o(mreq_ptag_o),
        .refill_done_i(refill_done_i), .tm_req_o(tm_req_o), .tm_we_o(tm_we_o),
        .tm_vbit_o(tm_vbit_o), .tm_flush_o(tm_flush_o), .tm_data_o(tm_data_o),
        .tm_addr_o(tm_addr_o), .tm_tag_way_i(rd_tag), .tm_vbit_i(rd_v),
        .state_o(state_o)
    );

    // Behavioural tag memory: one-cycle read, write, flush, plus a backdoor preload.
    logic [TW-1:0] mem_tag [NW][TD];
    logic          mem_v   [NW][TD];
    logic          bd_we = 0;
    logic [1:0]    bd_way = '0;
    logic [AW-1:0] bd_idx = '0;
    logic [TW-1:0] bd_tag = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < NW; w++) for (int s = 0; s < TD; s++) mem_v[w][s] <= 1'b0;
            rd_tag <= '0;
            rd_v   <= '0;
        end else begin
            if (tm_flush_o) for (int w = 0; w < NW; w++) for (int s = 0; s < TD; s++) mem_v[w][s] <= 1'b0;
            if (bd_we) begin
                mem_tag[bd_way][bd_idx] <= bd_tag;
                mem_v[bd_way][bd_idx]   <= 1'b1;
            end
            for (int w = 0; w < NW; w++) begin
                if (tm_req_o[w]) begin
                    if (tm_we_o) begin
                        mem_tag[w][tm_addr_o] <= tm_data_o;
                        mem_v[w][tm_addr_o]   <= tm_vbit_o;
                    end else begin
                        rd_tag[w*TW +: TW] <= mem_tag[w][tm_addr_o];
                        rd_v[w]            <= mem_v[w][tm_addr_o];
                    end
                end
            end
        end
    end

    // Scoreboard: {hit, way} of every response the stimulus implies.
    logic [4:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    // Output snapshot taken at the falling edge of each cycle.
    logic          s_ready, s_resp_v, s_mreq_v, s_we, s_vbit, s_flush;
    logic [NW-1:0] s_tm_req;
    logic [AW-1:0] s_mreq_idx, s_addr;
    logic [TW-1:0] s_mreq_ptag, s_data;
    logic [2:0]    s_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at negedge, score any response, return just after posedge.
    task automatic step();
        logic [5:0] exp;
        @(negedge clk);
        s_ready = lookup_ready_o; s_resp_v = resp_valid_o; s_mreq_v = mreq_valid_o;
        s_mreq_idx = mreq_idx_o; s_mreq_ptag = mreq_ptag_o; s_tm_req = tm_req_o;
        s_we = tm_we_o; s_vbit = tm_vbit_o; s_data = tm_data_o; s_addr = tm_addr_o;
        s_flush = tm_flush_o; s_state = state_o;
        if (resp_valid_o) begin
            exp = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 6'b0;
            check("resp", 32'({1'b1, resp_hit_o, resp_way_o}), 32'(exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] way, input logic [AW-1:0] idx, input logic [TW-1:0] tag);
        bd_we = 1; bd_way = way; bd_idx = idx; bd_tag = tag;
        step();
        bd_we = 0;
    endtask

    task automatic miss_seq(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                            input logic [NW-1:0] way, input int hold);
        lookup_valid_i = 1; lookup_idx_i = idx; lookup_ptag_i = tag;
        step();
        lookup_valid_i = 0;
        step();
        check("miss_no_resp", 32'(s_resp_v), 32'(0));
        check("miss_ready_low", 32'(s_ready), 32'(0));
        for (int i = 0; i < hold; i++) begin
            step();
            check("mreq_hold_valid", 32'(s_mreq_v), 32'(1));
            check("mreq_hold_idx", 32'(s_mreq_idx), 32'(idx));
            check("mreq_hold_ptag", 32'(s_mreq_ptag), 32'(tag));
        end
        mreq_ready_i = 1;
        step();
        check("mreq_valid", 32'(s_mreq_v), 32'(1));
        check("mreq_ptag", 32'(s_mreq_ptag), 32'(tag));
        mreq_ready_i = 0;
        step();
        check("wait_no_mreq", 32'(s_mreq_v), 32'(0));
        refill_done_i = 1;
        exp_q.push_back({1'b0, way});
        step();
        check("refill_cycle_no_write", 32'(s_we), 32'(0));
        refill_done_i = 0;
        step();
        check("wr_we", 32'(s_we), 32'(1));
        check("wr_req", 32'(s_tm_req), 32'(way));
        check("wr_vbit", 32'(s_vbit), 32'(1));
        check("wr_data", 32'(s_data), 32'(tag));
        check("wr_addr", 32'(s_addr), 32'(idx));
        check("wr_resp", 32'(s_resp_v), 32'(1));
        step();
        check("after_miss_ready", 32'(s_ready), 32'(1));
    endtask

    task automatic hit_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [NW-1:0] way);
        lookup_valid_i = 1; lookup_idx_i = idx; lookup_ptag_i = tag;
        exp_q.push_back({1'b1, way});
        step();
        lookup_valid_i = 0;
        step();
        check("hit_resp_valid", 32'(s_resp_v), 32'(1));
    endtask

    initial begin
        // Reset phase
        step(); step();
        check("rst_ready", 32'(s_ready), 32'(0));
        check("rst_resp", 32'(s_resp_v), 32'(0));
        check("rst_mreq", 32'(s_mreq_v), 32'(0));
        check("rst_tm_req", 32'(s_tm_req), 32'(0));
        check("rst_state", 32'(s_state), 32'(IDLE));
        rst_n = 1;
        step();
        check("idle_ready", 32'(s_ready), 32'(1));

        preload(2'd2, 6'd5, 20'h01234);
        preload(2'd1, 6'd6, 20'hABCDE);
        preload(2'd0, 6'd7, 20'h00778);
        preload(2'd3, 6'd7, 20'h00777);

        // Single hit, latency N+1
        lookup_valid_i = 1; lookup_idx_i = 6'd5; lookup_ptag_i = 20'h01234;
        exp_q.push_back(5'b1_0100);
        step();
        check("acc_ready", 32'(s_ready), 32'(1));
        check("acc_tm_req", 32'(s_tm_req), 32'hF);
        check("acc_tm_we", 32'(s_we), 32'(0));
        check("acc_tm_addr", 32'(s_addr), 32'(5));
        lookup_valid_i = 0;
        step();
        check("hit_latency", 32'(s_resp_v), 32'(1));
        check("hit_ready", 32'(s_ready), 32'(1));
        step();
        check("hit_back_idle", 32'(s_state), 32'(IDLE));

        // Back-to-back hits
        lookup_valid_i = 1; lookup_idx_i = 6'd5; lookup_ptag_i = 20'h01234;
        exp_q.push_back(5'b1_0100);
        step();
        lookup_idx_i = 6'd6; lookup_ptag_i = 20'hABCDE;
        exp_q.push_back(5'b1_0010);
        step();
        check("b2b_resp0", 32'(s_resp_v), 32'(1));
        lookup_idx_i = 6'd7; lookup_ptag_i = 20'h00777;
        exp_q.push_back(5'b1_1000);
        step();
        check("b2b_resp1", 32'(s_resp_v), 32'(1));
        lookup_valid_i = 0;
        step();
        check("b2b_resp2", 32'(s_resp_v), 32'(1));
        step();
        check("b2b_done", 32'(s_resp_v), 32'(0));

        // Miss on an empty set with a stalled miss request
        miss_seq(6'd9, 20'h09999, 4'b0001, 3);
        hit_lookup(6'd9, 20'h09999, 4'b0001);

        // Victim selection: first invalid, then round-robin
        miss_seq(6'd3, 20'h30000, 4'b0001, 0);
        miss_seq(6'd3, 20'h30001, 4'b0010, 0);
        miss_seq(6'd3, 20'h30002, 4'b0100, 0);
        miss_seq(6'd3, 20'h30003, 4'b1000, 0);
        miss_seq(6'd3, 20'h30004, 4'b0001, 0);
        miss_seq(6'd3, 20'h30005, 4'b0010, 0);
        hit_lookup(6'd3, 20'h30002, 4'b0100);

        // Flush while waiting for a refill
        lookup_valid_i = 1; lookup_idx_i = 6'd12; lookup_ptag_i = 20'h0C0C0;
        step();
        lookup_valid_i = 0;
        step();
        mreq_ready_i = 1;
        step();
        check("fl_mreq", 32'(s_mreq_v), 32'(1));
        mreq_ready_i = 0;
        flush_i = 1;
        step();
        check("fl_wait_ready", 32'(s_ready), 32'(0));
        check("fl_wait_noflush", 32'(s_flush), 32'(0));
        flush_i = 0;
        refill_done_i = 1;
        step();
        check("fl_refill_noflush", 32'(s_flush), 32'(0));
        refill_done_i = 0;
        step();
        check("fl_pulse", 32'(s_flush), 32'(1));
        check("fl_no_write", 32'(s_we), 32'(0));
        check("fl_no_resp", 32'(s_resp_v), 32'(0));
        check("fl_ready_low", 32'(s_ready), 32'(0));
        step();
        check("fl_pulse_end", 32'(s_flush), 32'(0));
        check("fl_ready_back", 32'(s_ready), 32'(1));
        miss_seq(6'd5, 20'h01234, 4'b0001, 0);

        // Flush coinciding with a hit in LOOKUP
        lookup_valid_i = 1; lookup_idx_i = 6'd5; lookup_ptag_i = 20'h01234;
        step();
        flush_i = 1;
        step();
        check("lkfl_no_resp", 32'(s_resp_v), 32'(0));
        check("lkfl_ready", 32'(s_ready), 32'(0));
        check("lkfl_no_req", 32'(s_tm_req), 32'(0));
        flush_i = 0; lookup_valid_i = 0;
        step();
        check("lkfl_pulse", 32'(s_flush), 32'(1));
        check("lkfl_ready_flush", 32'(s_ready), 32'(0));
        step();
        check("lkfl_idle", 32'(s_state), 32'(IDLE));

        // Flush in IDLE blocks a simultaneous lookup
        flush_i = 1; lookup_valid_i = 1; lookup_idx_i = 6'd9; lookup_ptag_i = 20'h09999;
        step();
        check("idfl_ready", 32'(s_ready), 32'(0));
        check("idfl_no_req", 32'(s_tm_req), 32'(0));
        flush_i = 0; lookup_valid_i = 0;
        step();
        check("idfl_pulse", 32'(s_flush), 32'(1));
        step();
        check("idfl_ready_back", 32'(s_ready), 32'(1));

        check("resp_all_seen", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
